// File: rtl/busmatrix_pkg.sv
// Shared encodings, FSM state and address-phase payload for the bus-matrix input stage.
package busmatrix_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TRANS_W = 2;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 3;
  localparam int unsigned PROT_W  = 4;

  localparam logic [TRANS_W-1:0] TRN_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] TRN_BUSY   = 2'b01;
  localparam logic [TRANS_W-1:0] TRN_NONSEQ = 2'b10;
  localparam logic [TRANS_W-1:0] TRN_SEQ    = 2'b11;

  localparam logic [BURST_W-1:0] BUR_SINGLE = 3'b000;
  localparam logic [BURST_W-1:0] BUR_INCR   = 3'b001;
  localparam logic [BURST_W-1:0] BUR_WRAP4  = 3'b010;
  localparam logic [BURST_W-1:0] BUR_INCR4  = 3'b011;
  localparam logic [BURST_W-1:0] BUR_WRAP8  = 3'b100;
  localparam logic [BURST_W-1:0] BUR_INCR8  = 3'b101;
  localparam logic [BURST_W-1:0] BUR_WRAP16 = 3'b110;
  localparam logic [BURST_W-1:0] BUR_INCR16 = 3'b111;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  typedef struct packed {
    logic               sel;
    logic [ADDR_W-1:0]  addr;
    logic [TRANS_W-1:0] trans;
    logic               write;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [PROT_W-1:0]  prot;
    logic               lock;
  } addr_phase_t;

endpackage

// File: rtl/busmatrix_hold_reg.sv
// Single-entry holding register for one captured AHB address phase.
module busmatrix_hold_reg
  import busmatrix_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  addr_phase_t i_d,
  output addr_phase_t o_q,
  output logic        o_valid
);

  addr_phase_t r_q;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_q     <= i_d;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/busmatrix_in_stage.sv
// AHB bus-matrix input stage: forwards granted transfers with zero latency, holds ungranted ones.
// Optional macro BUSMATRIX_SEQ_TO_NONSEQ_EN reissues a held SEQ beat as NONSEQ.
module busmatrix_in_stage
  import busmatrix_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic        req_port,
  output logic        HSELM,
  output logic [31:0] HADDRM,
  output logic [1:0]  HTRANSM,
  output logic        HWRITEM,
  output logic [2:0]  HSIZEM,
  output logic [2:0]  HBURSTM,
  output logic [3:0]  HPROTM,
  output logic        HMASTLOCKM,
  input  logic        granted,
  input  logic        HREADYM,
  input  logic        HRESPM
);

  state_e      r_state;
  state_e      w_next;
  logic        w_live;
  logic        w_blocked;
  logic        w_accept;
  logic        w_load;
  logic        w_clear;
  logic        w_hold_valid;
  logic [1:0]  w_held_trans;
  logic [1:0]  w_fwd_trans;
  addr_phase_t w_live_ap;
  addr_phase_t w_hold_ap;

  assign w_live_ap = '{sel: HSELS, addr: HADDRS, trans: HTRANSS, write: HWRITES,
                       size: HSIZES, burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};

  assign w_live    = HSELS & HTRANSS[1] & HREADYS;
  // While the downstream data phase stalls (incl. first error cycle) nothing new is taken.
  assign w_blocked = (r_state == ST_DATA) & ~HREADYM;
  assign w_accept  = w_live & ~w_blocked;

  assign w_fwd_trans = (!w_blocked && (w_live || (granted && !HTRANSS[1]))) ? HTRANSS : TRN_IDLE;

`ifdef BUSMATRIX_SEQ_TO_NONSEQ_EN
  assign w_held_trans = (w_hold_ap.trans == TRN_SEQ) ? TRN_NONSEQ : w_hold_ap.trans;
`else
  assign w_held_trans = w_hold_ap.trans;
`endif

  busmatrix_hold_reg u_hold (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_d     (w_live_ap),
    .o_q     (w_hold_ap),
    .o_valid (w_hold_valid)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state, hold-register control and slave/matrix outputs.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_clear    = 1'b0;
    HREADYOUTS = 1'b1;
    HRESPS     = RESP_OKAY;
    req_port   = w_accept;
    HSELM      = w_live_ap.sel;
    HADDRM     = w_live_ap.addr;
    HTRANSM    = w_fwd_trans;
    HWRITEM    = w_live_ap.write;
    HSIZEM     = w_live_ap.size;
    HBURSTM    = w_live_ap.burst;
    HPROTM     = w_live_ap.prot;
    HMASTLOCKM = w_live_ap.lock;

    case (r_state)
      ST_IDLE, ST_DATA: begin
        if (w_accept) begin
          if (granted && HREADYM) begin
            w_next = ST_DATA;
          end else begin
            w_next = ST_HOLD;
            w_load = 1'b1;
          end
        end else if (!w_blocked) begin
          w_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (granted && HREADYM) begin
          w_next  = ST_DATA;
          w_clear = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase

    if (r_state == ST_HOLD) begin
      HREADYOUTS = 1'b0;
      req_port   = 1'b1;
    end else if (r_state == ST_DATA) begin
      HREADYOUTS = HREADYM;
      HRESPS     = HRESPM;
    end

    if (w_hold_valid) begin
      HSELM      = w_hold_ap.sel;
      HADDRM     = w_hold_ap.addr;
      HTRANSM    = w_held_trans;
      HWRITEM    = w_hold_ap.write;
      HSIZEM     = w_hold_ap.size;
      HBURSTM    = w_hold_ap.burst;
      HPROTM     = w_hold_ap.prot;
      HMASTLOCKM = w_hold_ap.lock;
    end
  end

endmodule

// File: tb/tb_busmatrix_in_stage.sv
// Directed table-driven bench for busmatrix_in_stage plus a reset-in-HOLD sequence.
module tb_busmatrix_in_stage;

  logic        HCLK, HRESETn;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYOUTS, HRESPS, req_port;
  logic        HSELM, HWRITEM, HMASTLOCKM;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM;
  logic        granted, HREADYM, HRESPM;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BUSMATRIX_SEQ_TO_NONSEQ_EN
  localparam logic [1:0] SEQ_EXP = 2'b10;
`else
  localparam logic [1:0] SEQ_EXP = 2'b11;
`endif

  busmatrix_in_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .req_port(req_port), .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
    .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM),
    .HMASTLOCKM(HMASTLOCKM), .granted(granted), .HREADYM(HREADYM), .HRESPM(HRESPM)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        readys;
    logic        gr;
    logic        rdym;
    logic        respm;
    logic        e_req;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_rdy;
    logic        e_resp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic sel, logic [31:0] addr, logic [1:0] trans, logic readys,
                              logic gr, logic rdym, logic respm, logic e_req,
                              logic [1:0] e_trans, logic [31:0] e_addr, logic e_rdy,
                              logic e_resp);
    vec_t v;
    v.sel = sel; v.addr = addr; v.trans = trans; v.readys = readys;
    v.gr = gr; v.rdym = rdym; v.respm = respm;
    v.e_req = e_req; v.e_trans = e_trans; v.e_addr = e_addr;
    v.e_rdy = e_rdy; v.e_resp = e_resp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                       input logic readys, input logic gr, input logic rdym, input logic respm);
    HSELS = sel; HADDRS = addr; HTRANSS = trans; HREADYS = readys;
    granted = gr; HREADYM = rdym; HRESPM = respm;
    HWRITES = (addr == 32'h0000_1000);
  endtask

  initial begin
    // single granted write, then a 3-cycle ungranted hold
    vecs[0]  = mk(1, 32'h0000_1000, 2'b10, 1, 1, 1, 0,  1, 2'b10, 32'h0000_1000, 1, 0);
    vecs[1]  = mk(0, 32'h0,         2'b00, 1, 1, 1, 0,  0, 2'b00, 32'h0,         1, 0);
    vecs[2]  = mk(0, 32'h0,         2'b00, 1, 0, 0, 0,  0, 2'b00, 32'h0,         1, 0);
    vecs[3]  = mk(1, 32'h2000_0040, 2'b10, 1, 0, 1, 0,  1, 2'b10, 32'h2000_0040, 1, 0);
    vecs[4]  = mk(0, 32'h0,         2'b00, 0, 0, 1, 0,  1, 2'b10, 32'h2000_0040, 0, 0);
    vecs[5]  = mk(0, 32'h0,         2'b00, 0, 1, 0, 0,  1, 2'b10, 32'h2000_0040, 0, 0);
    vecs[6]  = mk(0, 32'h0,         2'b00, 0, 0, 1, 0,  1, 2'b10, 32'h2000_0040, 0, 0);
    vecs[7]  = mk(0, 32'h0,         2'b00, 0, 1, 1, 0,  1, 2'b10, 32'h2000_0040, 0, 0);
    vecs[8]  = mk(0, 32'h0,         2'b00, 1, 1, 1, 0,  0, 2'b00, 32'h0,         1, 0);
    // INCR4: second beat SEQ ungranted
    vecs[9]  = mk(1, 32'h0000_0100, 2'b10, 1, 1, 1, 0,  1, 2'b10, 32'h0000_0100, 1, 0);
    vecs[10] = mk(1, 32'h0000_0104, 2'b11, 1, 0, 1, 0,  1, 2'b11, 32'h0000_0104, 1, 0);
    vecs[11] = mk(0, 32'h0,         2'b00, 0, 0, 1, 0,  1, SEQ_EXP, 32'h0000_0104, 0, 0);
    vecs[12] = mk(0, 32'h0,         2'b00, 0, 1, 1, 0,  1, SEQ_EXP, 32'h0000_0104, 0, 0);
    vecs[13] = mk(0, 32'h0,         2'b00, 1, 1, 1, 0,  0, 2'b00, 32'h0,         1, 0);
    // two-cycle error response; transfer in first error cycle is dropped
    vecs[14] = mk(1, 32'h0000_0300, 2'b10, 1, 1, 1, 0,  1, 2'b10, 32'h0000_0300, 1, 0);
    vecs[15] = mk(1, 32'h0000_0304, 2'b10, 1, 1, 0, 1,  0, 2'b00, 32'h0000_0304, 0, 1);
    vecs[16] = mk(0, 32'h0,         2'b00, 1, 1, 1, 1,  0, 2'b00, 32'h0,         1, 1);
    vecs[17] = mk(0, 32'h0,         2'b00, 1, 0, 0, 0,  0, 2'b00, 32'h0,         1, 0);
    // back-to-back with two wait states
    vecs[18] = mk(1, 32'h0000_0400, 2'b10, 1, 1, 1, 0,  1, 2'b10, 32'h0000_0400, 1, 0);
    vecs[19] = mk(1, 32'h0000_0404, 2'b10, 0, 1, 0, 0,  0, 2'b00, 32'h0000_0404, 0, 0);
    vecs[20] = mk(1, 32'h0000_0404, 2'b10, 0, 1, 0, 0,  0, 2'b00, 32'h0000_0404, 0, 0);
    vecs[21] = mk(1, 32'h0000_0404, 2'b10, 1, 1, 1, 0,  1, 2'b10, 32'h0000_0404, 1, 0);
    vecs[22] = mk(0, 32'h0,         2'b00, 1, 1, 1, 0,  0, 2'b00, 32'h0,         1, 0);

    HSIZES = 3'b010; HBURSTS = 3'b011; HPROTS = 4'b0011; HMASTLOCKS = 1'b0;
    drive(0, 32'h0, 2'b00, 1, 0, 1, 0);
    HRESETn = 1'b0;
    #1;
    chk("rst req_port", 32'(req_port), 32'h0);
    chk("rst HTRANSM", 32'(HTRANSM), 32'h0);
    chk("rst HREADYOUTS", 32'(HREADYOUTS), 32'h1);
    chk("rst HRESPS", 32'(HRESPS), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge HCLK);
      drive(vecs[i].sel, vecs[i].addr, vecs[i].trans, vecs[i].readys,
            vecs[i].gr, vecs[i].rdym, vecs[i].respm);
      #2;
      chk($sformatf("v%0d req_port", i), 32'(req_port), 32'(vecs[i].e_req));
      chk($sformatf("v%0d HTRANSM", i), 32'(HTRANSM), 32'(vecs[i].e_trans));
      chk($sformatf("v%0d HADDRM", i), HADDRM, vecs[i].e_addr);
      chk($sformatf("v%0d HREADYOUTS", i), 32'(HREADYOUTS), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d HRESPS", i), 32'(HRESPS), 32'(vecs[i].e_resp));
    end

    // reset pulse while a transfer is held
    @(negedge HCLK);
    drive(1, 32'h0000_0500, 2'b10, 1, 0, 1, 0);
    #2;
    chk("hr capture req_port", 32'(req_port), 32'h1);
    @(negedge HCLK);
    drive(0, 32'h0, 2'b00, 0, 0, 1, 0);
    #2;
    chk("hr hold HREADYOUTS", 32'(HREADYOUTS), 32'h0);
    chk("hr hold HADDRM", HADDRM, 32'h0000_0500);
    #1 HRESETn = 1'b0;
    #1;
    chk("hr rst req_port", 32'(req_port), 32'h0);
    chk("hr rst HTRANSM", 32'(HTRANSM), 32'h0);
    chk("hr rst HREADYOUTS", 32'(HREADYOUTS), 32'h1);
    chk("hr rst HRESPS", 32'(HRESPS), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    drive(0, 32'h0, 2'b00, 1, 1, 0, 0);
    #2;
    chk("hr post req_port", 32'(req_port), 32'h0);
    chk("hr post HREADYOUTS", 32'(HREADYOUTS), 32'h1);
    chk("hr post HTRANSM", 32'(HTRANSM), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
